// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and picks the next one from sequential,
// branch, jump or return sources, with a small circular return-address stack.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter int              INC          = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow,
    output logic            ret_underflow
);

    localparam int              PW         = $clog2(RAS_DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    localparam logic [CW-1:0]   DEPTH_C    = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   wp_q, wp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            mis_q, mis_d;
    logic            unf_q, unf_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    logic            push;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic [PW-1:0]   wp_m1;

    assign pc_plus_inc   = pc_q + INC_V;
    assign wp_m1         = wp_q - PW'(1);
    assign pc            = pc_q;
    assign misaligned    = mis_q;
    assign ret_underflow = unf_q;
    assign ras_overflow  = ovf_q;
    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == DEPTH_C);

    always_comb begin
        pc_d     = pc_q;
        wp_d     = wp_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mis_d    = 1'b0;
        unf_d    = 1'b0;
        push     = 1'b0;
        redirect = 1'b0;
        target   = pc_plus_inc;

        if (stall) begin
            pc_d = pc_q;
        end else if (jump) begin
            redirect = 1'b1;
            target   = jump_target;
            push     = call;
        end else if (branch_taken) begin
            redirect = 1'b1;
            target   = pc_q + branch_offset;
        end else if (ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[wp_m1];
                wp_d  = wp_m1;
                cnt_d = cnt_q - CW'(1);
            end else begin
                pc_d  = pc_plus_inc;
                unf_d = 1'b1;
            end
        end else begin
            pc_d = pc_plus_inc;
        end

        // Redirect targets are force-aligned; the mask is zero when INC is 1.
        if (redirect) begin
            pc_d  = target & ~ALIGN_MASK;
            mis_d = |(target & ALIGN_MASK);
        end

        if (push) begin
            wp_d = wp_q + PW'(1);
            if (cnt_q == DEPTH_C) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            mis_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            mis_q <= mis_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_q[wp_q] <= pc_plus_inc;
        end
    end

endmodule
